// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// Optional feature macro used by the controller: BOOTH_APPROX_EN.
package booth_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // One Booth digit: magnitude 0 (zero), 1x or 2x (two), and sign (neg).
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  // Accumulator width for an n x n product: 2n bits plus two guard bits
  // so the signed partial products never overflow the running sum.
  function automatic int unsigned booth_acc_w(input int unsigned n);
    return 2 * n + 2;
  endfunction

  // Triplet {y[2i+1], y[2i], y[2i-1]} to digit control.
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b000, 3'b111: d = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
      3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
      3'b011:         d = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
      3'b100:         d = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
      3'b101, 3'b110: d = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
      default:        d = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial-product generator: selects 0, x or 2x and
// negates in two's complement, producing an (N+2)-bit signed value.
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]  i_x,
  input  booth_digit_t  i_dig,
  output logic [N+1:0]  o_pp
);

  logic [N+1:0] w_mag;

  // Magnitude select followed by optional negation.
  always_comb begin
    w_mag = '0;
    if (!i_dig.zero) begin
      w_mag = i_dig.two ? {1'b0, i_x, 1'b0} : {2'b00, i_x};
    end
    o_pp = i_dig.neg ? (~w_mag + (N+2)'(1)) : w_mag;
  end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Iterative radix-4 Booth multiplier controller: one Booth digit per clock
// into a 2N+2-bit accumulator, valid/ready handshake on both sides.
// Optional macro BOOTH_APPROX_EN adds cfg_approx, which rounds the low M
// bits of the multiplicand to a single majority bit at capture.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready high)
// RUN   | retiring one Booth digit per cycle, K+1 cycles
// DONE  | product presented on out_p until out_ready
module booth_r4_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = 32,
  parameter int K = N / 2,
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy
`ifdef BOOTH_APPROX_EN
  ,
  input  logic           cfg_approx
`endif
);

  localparam int AW = booth_acc_w(N);
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(K);

  booth_state_e   r_state;
  booth_state_e   w_state_nxt;
  logic [N-1:0]   r_x;
  logic [N-1:0]   w_x_cap;
  logic [N+2:0]   r_y;
  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_acc;
  logic [AW-1:0]  w_pp_sh;
  logic [AW-1:0]  w_acc_nxt;
  logic [2*N-1:0] r_out_p;
  logic [N+1:0]   w_pp;
  booth_digit_t   w_dig;
  logic           w_accept;
  logic           w_last;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_DIGIT);

  // r_y is shifted right two bits per digit, so the current triplet is
  // always its bottom three bits (bit 0 starts as y[-1] = 0).
  assign w_dig = booth_decode(r_y[2:0]);

  booth_r4_pp_gen #(
    .N (N)
  ) u_pp_gen (
    .i_x   (r_x),
    .i_dig (w_dig),
    .o_pp  (w_pp)
  );

  assign w_pp_sh   = {{N{w_pp[N+1]}}, w_pp} << {r_cnt, 1'b0};
  assign w_acc_nxt = r_acc + w_pp_sh;

`ifdef BOOTH_APPROX_EN
  localparam int PW = $clog2(N + 1) + 1;
  logic [PW-1:0] w_pop;

  // Multiplicand capture value: low M-1 bits cleared, bit M-1 becomes the
  // majority vote of the original low M bits.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < M; i++) begin
      w_pop = w_pop + PW'(in_x[i]);
    end
    w_x_cap = in_x;
    if (cfg_approx) begin
      w_x_cap        = in_x & ({N{1'b1}} << M);
      w_x_cap[M-1]   = (w_pop > PW'(M / 2));
    end
  end
`else
  assign w_x_cap = in_x;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
    out_p     = r_out_p;
  end

  // Operand capture, digit counter, accumulator and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_out_p <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= w_x_cap;
            r_y   <= {2'b00, in_y, 1'b0};
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_y   <= {2'b00, r_y[N+2:2]};
          if (w_last) r_out_p <= w_acc_nxt[2*N-1:0];
          else        r_cnt   <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
